// File: rtl/pulse_spacer_if.sv
// pulse_spacer_if: event/status bundle between the pulse source and pulse_spacer.
// The flush signal exists only when PULSE_SPACER_FLUSH_EN is defined.
interface pulse_spacer_if #(
   parameter int CNT_W = 4
);
   logic             pls_in;
   logic             clr_ovf;
`ifdef PULSE_SPACER_FLUSH_EN
   logic             flush;
`endif
   logic             pls_out;
   logic [CNT_W-1:0] pending;
   logic             overflow;
   logic             busy;

   modport master (
      output pls_in, clr_ovf,
`ifdef PULSE_SPACER_FLUSH_EN
      output flush,
`endif
      input  pls_out, pending, overflow, busy
   );

   modport slave (
      input  pls_in, clr_ovf,
`ifdef PULSE_SPACER_FLUSH_EN
      input  flush,
`endif
      output pls_out, pending, overflow, busy
   );
endinterface

// File: rtl/pulse_spacer.sv
// pulse_spacer: queues single-cycle events and re-emits them >= GAP cycles apart, 1-cycle latency when idle.
// No backpressure: events beyond 2^CNT_W-1 queued are dropped into a sticky overflow; flush via PULSE_SPACER_FLUSH_EN.
module pulse_spacer #(
   parameter int CNT_W = 4,
   parameter int GAP   = 4
) (
   input  logic          clock_a,
   input  logic          async_rst_n,
   pulse_spacer_if.slave sp
);
   localparam int               GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CNT_W:0]   MAX_WIDE   = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W-1:0] MAX_CNT    = {CNT_W{1'b1}};
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, HOLD = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             pls_out_q;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             issue, drop, flush;
   logic [CNT_W:0]   sum;

`ifdef PULSE_SPACER_FLUSH_EN
   assign flush = sp.flush;
`else
   assign flush = 1'b0;
`endif

   // IDLE/READY both mean the holdoff has expired; an IDLE pulse bypasses the queue.
   always_comb begin
      issue     = !flush && ((state_q == READY) || ((state_q == IDLE) && sp.pls_in));
      sum       = {1'b0, pending_q} + (CNT_W+1)'(sp.pls_in) - (CNT_W+1)'(issue);
      drop      = !flush && (sum > MAX_WIDE);
      pending_d = flush ? '0 : (drop ? MAX_CNT : sum[CNT_W-1:0]);
      gap_d     = '0;
      if (!flush) begin
         if (issue)
            gap_d = GAP_RELOAD;
         else if (gap_q != '0)
            gap_d = gap_q - GAP_W'(1);
      end
      ovf_d     = drop ? 1'b1 : (sp.clr_ovf ? 1'b0 : ovf_q);
      busy_d    = (pending_d != '0) || (gap_d != '0);
      state_d   = (gap_d != '0) ? HOLD : ((pending_d != '0) ? READY : IDLE);
   end

   always_ff @(posedge clock_a or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         gap_q     <= '0;
         pls_out_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         gap_q     <= gap_d;
         pls_out_q <= issue;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
      end
   end

   assign sp.pls_out  = pls_out_q;
   assign sp.pending  = pending_q;
   assign sp.overflow = ovf_q;
   assign sp.busy     = busy_q;
endmodule

// File: tb/tb_pulse_spacer.sv
// tb_pulse_spacer: scoreboard bench; a timestamp-based model predicts each cycle's outputs.
module tb_pulse_spacer;
   localparam int CNT_W = 4;
   localparam int GAP   = 4;
   localparam int MAX   = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pulse_spacer_if #(.CNT_W(CNT_W)) sp ();

   pulse_spacer #(.CNT_W(CNT_W), .GAP(GAP)) dut (
      .clock_a     (clk),
      .async_rst_n (rst_n),
      .sp          (sp)
   );

   typedef struct {
      int pls;
      int pend;
      int ovf;
      int busy;
   } exp_t;

   exp_t sbq[$];

   int m_pend, m_since, m_ovf;
   int n_vec, n_err;
   int cyc, n_pulses, last_pulse, min_gap, peak;

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pend     = 0;
      m_since    = GAP;
      m_ovf      = 0;
      sbq.delete();
   endtask

   task automatic stats_reset();
      n_pulses   = 0;
      last_pulse = -1000;
      min_gap    = 1000;
      peak       = 0;
   endtask

   task automatic step(input bit in, input bit clr, input bit fl);
      exp_t e;
      int   iss, nxt;
      @(negedge clk);
      sp.pls_in  = in;
      sp.clr_ovf = clr;
`ifdef PULSE_SPACER_FLUSH_EN
      sp.flush   = fl;
`endif
      // model: a pulse may issue once GAP cycles have passed since the previous one
      iss = (!fl && m_since >= GAP && (m_pend > 0 || in)) ? 1 : 0;
      if (fl) begin
         m_pend  = 0;
         m_since = GAP;
         if (clr) m_ovf = 0;
      end else begin
         nxt = m_pend + int'(in) - iss;
         if (nxt > MAX) begin
            m_pend = MAX;
            m_ovf  = 1;
         end else begin
            m_pend = nxt;
            if (clr) m_ovf = 0;
         end
         m_since = iss ? 1 : ((m_since < GAP) ? m_since + 1 : GAP);
      end
      e.pls  = iss;
      e.pend = m_pend;
      e.ovf  = m_ovf;
      e.busy = (m_pend != 0 || m_since < GAP) ? 1 : 0;
      sbq.push_back(e);

      @(posedge clk);
      #1;
      cyc++;
      e = sbq.pop_front();
      check_val("pls_out",  int'(sp.pls_out),  e.pls);
      check_val("pending",  int'(sp.pending),  e.pend);
      check_val("overflow", int'(sp.overflow), e.ovf);
      check_val("busy",     int'(sp.busy),     e.busy);
      if (sp.pls_out) begin
         n_pulses++;
         if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
      end
      if (int'(sp.pending) > peak) peak = int'(sp.pending);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      sp.pls_in  = 1'b0;
      sp.clr_ovf = 1'b0;
`ifdef PULSE_SPACER_FLUSH_EN
      sp.flush   = 1'b0;
`endif
      model_reset();
      stats_reset();

      #12;
      check_val("rst_pls_out",  int'(sp.pls_out),  0);
      check_val("rst_pending",  int'(sp.pending),  0);
      check_val("rst_overflow", int'(sp.overflow), 0);
      check_val("rst_busy",     int'(sp.busy),     0);
      @(negedge clk);
      rst_n = 1'b1;

      // single pulse
      step(1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      check_val("single_pulses", n_pulses, 1);

      // burst of three
      stats_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0);
      check_val("burst_pulses", n_pulses, 3);
      check_val("burst_gap", min_gap, GAP);

      // saturation
      stats_reset();
      for (int i = 0; i < 24; i++) step(1, 0, 0);
      for (int i = 0; i < 70; i++) step(0, 0, 0);
      check_val("sat_pulses", n_pulses, 21);
      check_val("sat_peak", peak, MAX);
      check_val("sat_ovf", int'(sp.overflow), 1);
      check_val("sat_gap_ok", (min_gap >= GAP) ? 1 : 0, 1);

      // overflow clear alone, then clear coincident with a drop
      step(0, 1, 0);
      check_val("clr_alone", int'(sp.overflow), 0);
      for (int i = 0; i < 21; i++) step(1, 0, 0);
      check_val("full_no_drop_ovf", int'(sp.overflow), 0);
      check_val("full_pending", int'(sp.pending), MAX);
      step(1, 1, 0);
      check_val("clr_vs_drop", int'(sp.overflow), 1);
      step(0, 1, 0);
      for (int i = 0; i < 70; i++) step(0, 0, 0);

      // asynchronous reset mid-burst
      for (int i = 0; i < 7; i++) step(1, 0, 0);
      check_val("mid_pending", int'(sp.pending), 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_pls_out",  int'(sp.pls_out),  0);
      check_val("arst_pending",  int'(sp.pending),  0);
      check_val("arst_overflow", int'(sp.overflow), 0);
      check_val("arst_busy",     int'(sp.busy),     0);
      model_reset();
      sp.pls_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stats_reset();
      for (int i = 0; i < 50; i++) step(0, 0, 0);
      check_val("post_rst_pulses", n_pulses, 0);

`ifdef PULSE_SPACER_FLUSH_EN
      for (int i = 0; i < 10; i++) step(1, 0, 0);
      check_val("pre_flush_pending", int'(sp.pending), 7);
      step(0, 0, 1);
      check_val("flush_pending", int'(sp.pending), 0);
      check_val("flush_busy", int'(sp.busy), 0);
      stats_reset();
      for (int i = 0; i < 6; i++) step(0, 0, 0);
      check_val("flush_quiet", n_pulses, 0);
      step(1, 0, 0);
      check_val("flush_restart", int'(sp.pls_out), 1);
      for (int i = 0; i < 6; i++) step(0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
